// File: rtl/alu_test_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : alu_test_sequencer_if
// Purpose : operand/opcode request and result handshake between the
//           sequencer (master) and the ALU under test (slave).
// Rev     : 1.0
// ----------------------------------------------------------------------------
interface alu_test_sequencer_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       OP;
  logic             req;
  logic [WIDTH-1:0] res;
  logic             res_valid;

  modport master (output A, B, OP, req, input res, res_valid);
  modport slave  (input A, B, OP, req, output res, res_valid);
endinterface
`default_nettype wire

// File: rtl/alu_test_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : alu_test_sequencer
// Purpose : LFSR-driven stimulus run of NUM_VEC vectors against the shift/
//           logic ALU, checked by an internal golden model.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module alu_test_sequencer #(
  parameter int               WIDTH   = 7,
  parameter int               NUM_VEC = 8,
  parameter logic [WIDTH-1:0] SEED    = 7'h55,
  parameter logic [WIDTH-1:0] TAPS    = 7'h60,
  parameter int               TIMEOUT = 16,
  localparam int              ERRW    = $clog2(NUM_VEC + 1),
  localparam int              IDXW    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             start,
  alu_test_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERRW-1:0]       err_count,
  output logic [IDXW-1:0]       vec_idx
);

  localparam int               TMOW     = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? '1 : SEED;
  localparam logic [TMOW-1:0]  TMO_LAST = TMOW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NUM_VEC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [TMOW-1:0]  tmo_q, tmo_d;
  logic [WIDTH-1:0] w_gold;
  logic             w_b_oor;

  // Shift amounts of WIDTH or more flush the operand completely.
  assign w_b_oor = (32'(b_q) >= 32'(WIDTH));

  always_comb begin
    w_gold = '0;
    case (op_q)
      2'b00:   w_gold = ~a_q;
      2'b01:   if (!w_b_oor) w_gold = a_q >> b_q;
      2'b10:   if (!w_b_oor) w_gold = a_q << b_q;
      default: w_gold = a_q & b_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    req_d   = 1'b0;
    err_d   = err_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_d  = SEED_EFF;
          idx_d   = '0;
          err_d   = '0;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        a_d     = lfsr_q;
        b_d     = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1]};
        op_d    = 2'(idx_q);
        req_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result on the last allowed cycle is still compared, not timed out.
        if (bus.res_valid) begin
          if (bus.res != w_gold) err_d = err_q + 1'b1;
          state_d = S_NEXT;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = err_q + 1'b1;
          state_d = S_NEXT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_NEXT: begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT) || (state_d == S_NEXT);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.A     = a_q;
  assign bus.B     = b_q;
  assign bus.OP    = op_q;
  assign bus.req   = req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_idx   = idx_q;

endmodule
`default_nettype wire
